// File: rtl/microseq_nslogic_if.sv
// Bus between the control store / instruction decoder and the microsequencer.
// The sequencer owns the slave side: it consumes the control-word fields,
// decoder targets, flags and stall, and returns the micro-address and status.
interface microseq_nslogic_if #(
    parameter int AW = 5,
    parameter int SD = 4
);
    localparam int SPW = $clog2(SD + 1);

    logic [2:0]     nssel;
    logic [1:0]     csel;
    logic           cpol;
    logic [AW-1:0]  dbin;
    logic [AW-1:0]  ibin;
    logic [AW-1:0]  sbin;
    logic [3:0]     cc;
    logic           stall;
    logic [AW-1:0]  uaddr;
    logic [SPW-1:0] sp;
    logic           halted;
    logic           err_ovf;
    logic           err_unf;

    modport master (
        output nssel, csel, cpol, dbin, ibin, sbin, cc, stall,
        input  uaddr, sp, halted, err_ovf, err_unf
    );

    modport slave (
        input  nssel, csel, cpol, dbin, ibin, sbin, cc, stall,
        output uaddr, sp, halted, err_ovf, err_unf
    );
endinterface

// File: rtl/microseq_nslogic.sv
// Registered next-state generator for the microprogrammed CPU.
// Selects the next micro-address from sequential, direct, dispatch, conditional
// branch or micro-subroutine sources, keeps a small return stack, and records
// halt and stack error conditions as sticky flags.
module microseq_nslogic #(
    parameter int AW        = 5,
    parameter int SD        = 4,
    parameter int RESET_VEC = 0
) (
    input  logic              clock,
    input  logic              resetn,
    microseq_nslogic_if.slave bus
);
    localparam int SPW = $clog2(SD + 1);
    localparam int IW  = (SD > 1) ? $clog2(SD) : 1;

    localparam logic [2:0] NS_SEQ    = 3'b000;
    localparam logic [2:0] NS_JMP    = 3'b001;
    localparam logic [2:0] NS_DISP_I = 3'b010;
    localparam logic [2:0] NS_DISP_S = 3'b011;
    localparam logic [2:0] NS_BR     = 3'b100;
    localparam logic [2:0] NS_CALL   = 3'b101;
    localparam logic [2:0] NS_RET    = 3'b110;
    localparam logic [2:0] NS_HALT   = 3'b111;

    localparam logic [SPW-1:0] SP_FULL = SPW'(SD);

    logic [AW-1:0]  uaddr_q, uaddr_d, seq_addr;
    logic [SPW-1:0] sp_q, sp_d, sp_dec;
    logic           halted_q, halted_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic           push;
    logic           cond;
    logic [1:0]     flag_idx;
    logic [IW-1:0]  push_idx, pop_idx;
    logic [AW-1:0]  stack [SD];

    // cc is packed {Z,N,C,V}, so csel counts down from the top bit.
    assign seq_addr = uaddr_q + 1'b1;
    assign flag_idx = 2'd3 - bus.csel;
    assign cond     = bus.cc[flag_idx] ^ bus.cpol;
    assign sp_dec   = sp_q - 1'b1;
    assign push_idx = sp_q[IW-1:0];
    assign pop_idx  = sp_dec[IW-1:0];

    // Next-state selection; stall leaves every default (hold) in place.
    always_comb begin
        uaddr_d  = uaddr_q;
        sp_d     = sp_q;
        halted_d = halted_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        push     = 1'b0;
        if (!bus.stall) begin
            case (bus.nssel)
                NS_SEQ:    uaddr_d = seq_addr;
                NS_JMP:    uaddr_d = bus.dbin;
                NS_DISP_I: uaddr_d = bus.ibin;
                NS_DISP_S: uaddr_d = bus.sbin;
                NS_BR:     uaddr_d = cond ? bus.dbin : seq_addr;
                NS_CALL: begin
                    if (sp_q != SP_FULL) begin
                        push    = 1'b1;
                        sp_d    = sp_q + 1'b1;
                        uaddr_d = bus.dbin;
                    end else begin
                        uaddr_d = seq_addr;
                        ovf_d   = 1'b1;
                    end
                end
                NS_RET: begin
                    if (sp_q != '0) begin
                        uaddr_d = stack[pop_idx];
                        sp_d    = sp_dec;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                NS_HALT:   halted_d = 1'b1;
                default:   uaddr_d = uaddr_q;
            endcase
        end
    end

    // Control state registers; reset aborts any pending push or pop at once.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            uaddr_q  <= AW'(RESET_VEC);
            sp_q     <= '0;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            uaddr_q  <= uaddr_d;
            sp_q     <= sp_d;
            halted_q <= halted_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Return stack storage; contents are meaningless after reset so no reset here.
    always_ff @(posedge clock) begin
        if (push) begin
            stack[push_idx] <= seq_addr;
        end
    end

    assign bus.uaddr   = uaddr_q;
    assign bus.sp      = sp_q;
    assign bus.halted  = halted_q;
    assign bus.err_ovf = ovf_q;
    assign bus.err_unf = unf_q;
endmodule

// File: tb/tb_microseq_nslogic.sv
// Testbench for microseq_nslogic (AW=5, SD=4, RESET_VEC=0).
// Directed vector table, asynchronous reset corner case, then random
// stimulus compared against a queue-based behavioural model.
module tb_microseq_nslogic;
    localparam int AW = 5;
    localparam int SD = 4;

    localparam logic [2:0] SEQ  = 3'd0;
    localparam logic [2:0] JMP  = 3'd1;
    localparam logic [2:0] DSPI = 3'd2;
    localparam logic [2:0] DSPS = 3'd3;
    localparam logic [2:0] BR   = 3'd4;
    localparam logic [2:0] CALL = 3'd5;
    localparam logic [2:0] RET  = 3'd6;
    localparam logic [2:0] HALT = 3'd7;

    typedef struct {
        logic [2:0] nssel;
        logic [1:0] csel;
        logic       cpol;
        logic [4:0] dbin;
        logic [4:0] ibin;
        logic [4:0] sbin;
        logic [3:0] cc;
        logic       stall;
        logic [4:0] exp_uaddr;
        logic [2:0] exp_sp;
        logic       exp_halted;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    logic clock;
    logic resetn;
    int   checks;
    int   failures;
    vec_t vecs[$];

    int   m_uaddr;
    int   m_stack[$];
    bit   m_halted;
    bit   m_ovf;
    bit   m_unf;

    microseq_nslogic_if #(.AW(AW), .SD(SD)) bus ();

    microseq_nslogic #(.AW(AW), .SD(SD), .RESET_VEC(0)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case anything stalls the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] ns, input logic [1:0] cs, input logic cp,
                                 input logic [4:0] db, input logic [4:0] ib, input logic [4:0] sb,
                                 input logic [3:0] c, input logic st);
        bus.nssel = ns;
        bus.csel  = cs;
        bus.cpol  = cp;
        bus.dbin  = db;
        bus.ibin  = ib;
        bus.sbin  = sb;
        bus.cc    = c;
        bus.stall = st;
        @(posedge clock);
        #1;
    endtask

    task automatic addVec(input logic [2:0] ns, input logic [1:0] cs, input logic cp,
                          input logic [4:0] db, input logic [4:0] ib, input logic [4:0] sb,
                          input logic [3:0] c, input logic st, input logic [4:0] eu,
                          input logic [2:0] esp, input logic eh, input logic eo, input logic eun);
        vec_t v;
        v = '{ns, cs, cp, db, ib, sb, c, st, eu, esp, eh, eo, eun};
        vecs.push_back(v);
    endtask

    task automatic modelReset();
        m_uaddr  = 0;
        m_stack  = {};
        m_halted = 0;
        m_ovf    = 0;
        m_unf    = 0;
    endtask

    task automatic doReset();
        resetn = 1'b0;
        applyStimulus(SEQ, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0);
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        modelReset();
    endtask

    // Behavioural reference: plain integer arithmetic and a queue for the stack.
    task automatic modelStep(input int ns, input int cs, input int cp, input int db,
                             input int ib, input int sb, input int c, input int st);
        int nxt;
        int flag;
        if (st != 0) return;
        nxt = (m_uaddr + 1) % 32;
        case (ns)
            0: m_uaddr = nxt;
            1: m_uaddr = db;
            2: m_uaddr = ib;
            3: m_uaddr = sb;
            4: begin
                flag = (c >> (3 - cs)) & 1;
                if ((flag ^ cp) != 0) m_uaddr = db;
                else m_uaddr = nxt;
            end
            5: begin
                if (m_stack.size() < SD) begin
                    m_stack.push_back(nxt);
                    m_uaddr = db;
                end else begin
                    m_uaddr = nxt;
                    m_ovf   = 1;
                end
            end
            6: begin
                if (m_stack.size() > 0) m_uaddr = m_stack.pop_back();
                else m_unf = 1;
            end
            default: m_halted = 1;
        endcase
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_uaddr"}, 32'(bus.uaddr), 32'(m_uaddr));
        checkOutput({tag, "_sp"}, 32'(bus.sp), 32'(m_stack.size()));
        checkOutput({tag, "_halted"}, 32'(bus.halted), 32'(m_halted));
        checkOutput({tag, "_ovf"}, 32'(bus.err_ovf), 32'(m_ovf));
        checkOutput({tag, "_unf"}, 32'(bus.err_unf), 32'(m_unf));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;

        //     ns    cs  cp db  ib  sb  cc       st  uaddr sp h o u
        addVec(SEQ,  0, 0,  0,  0,  0, 4'b0000, 0,  1, 0, 0,0,0);
        addVec(SEQ,  0, 0,  0,  0,  0, 4'b0000, 0,  2, 0, 0,0,0);
        addVec(SEQ,  0, 0,  0,  0,  0, 4'b0000, 0,  3, 0, 0,0,0);
        addVec(JMP,  0, 0, 31,  0,  0, 4'b0000, 0, 31, 0, 0,0,0);
        addVec(SEQ,  0, 0,  0,  0,  0, 4'b0000, 0,  0, 0, 0,0,0);
        addVec(JMP,  0, 0,  5,  0,  0, 4'b0000, 0,  5, 0, 0,0,0);
        addVec(BR,   0, 0, 12,  0,  0, 4'b1000, 0, 12, 0, 0,0,0);
        addVec(JMP,  0, 0,  5,  0,  0, 4'b0000, 0,  5, 0, 0,0,0);
        addVec(BR,   0, 1, 12,  0,  0, 4'b1000, 0,  6, 0, 0,0,0);
        addVec(JMP,  0, 0,  5,  0,  0, 4'b0000, 0,  5, 0, 0,0,0);
        addVec(BR,   3, 0, 12,  0,  0, 4'b0001, 0, 12, 0, 0,0,0);
        addVec(BR,   1, 0, 25,  0,  0, 4'b1000, 0, 13, 0, 0,0,0);
        addVec(DSPI, 0, 0,  3, 17,  4, 4'b0000, 0, 17, 0, 0,0,0);
        addVec(DSPS, 0, 0,  3,  4,  9, 4'b0000, 0,  9, 0, 0,0,0);
        addVec(JMP,  0, 0, 20,  0,  0, 4'b0000, 1,  9, 0, 0,0,0);
        addVec(CALL, 0, 0, 20,  0,  0, 4'b0000, 1,  9, 0, 0,0,0);
        addVec(JMP,  0, 0,  2,  0,  0, 4'b0000, 0,  2, 0, 0,0,0);
        addVec(CALL, 0, 0,  7,  0,  0, 4'b0000, 0,  7, 1, 0,0,0);
        addVec(CALL, 0, 0, 11,  0,  0, 4'b0000, 0, 11, 2, 0,0,0);
        addVec(CALL, 0, 0, 14,  0,  0, 4'b0000, 0, 14, 3, 0,0,0);
        addVec(CALL, 0, 0, 20,  0,  0, 4'b0000, 0, 20, 4, 0,0,0);
        addVec(CALL, 0, 0,  5,  0,  0, 4'b0000, 0, 21, 4, 0,1,0);
        addVec(RET,  0, 0,  0,  0,  0, 4'b0000, 1, 21, 4, 0,1,0);
        addVec(RET,  0, 0,  0,  0,  0, 4'b0000, 0, 15, 3, 0,1,0);
        addVec(RET,  0, 0,  0,  0,  0, 4'b0000, 0, 12, 2, 0,1,0);
        addVec(RET,  0, 0,  0,  0,  0, 4'b0000, 0,  8, 1, 0,1,0);
        addVec(RET,  0, 0,  0,  0,  0, 4'b0000, 0,  3, 0, 0,1,0);
        addVec(RET,  0, 0,  0,  0,  0, 4'b0000, 0,  3, 0, 0,1,1);
        addVec(JMP,  0, 0,  6,  0,  0, 4'b0000, 0,  6, 0, 0,1,1);
        addVec(HALT, 0, 0,  9,  0,  0, 4'b0000, 0,  6, 0, 1,1,1);
        addVec(HALT, 0, 0,  9,  0,  0, 4'b0000, 0,  6, 0, 1,1,1);
        addVec(JMP,  0, 0,  1,  0,  0, 4'b0000, 0,  1, 0, 1,1,1);
        addVec(SEQ,  0, 0,  0,  0,  0, 4'b0000, 0,  2, 0, 1,1,1);
        addVec(CALL, 0, 0, 20,  0,  0, 4'b0000, 0, 20, 1, 1,1,1);

        // Reset state.
        applyStimulus(SEQ, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0);
        checkOutput("reset_uaddr", 32'(bus.uaddr), 32'd0);
        checkOutput("reset_sp", 32'(bus.sp), 32'd0);
        checkOutput("reset_halted", 32'(bus.halted), 32'd0);
        checkOutput("reset_ovf", 32'(bus.err_ovf), 32'd0);
        checkOutput("reset_unf", 32'(bus.err_unf), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].nssel, vecs[i].csel, vecs[i].cpol, vecs[i].dbin,
                          vecs[i].ibin, vecs[i].sbin, vecs[i].cc, vecs[i].stall);
            checkOutput($sformatf("vec%0d_uaddr", i), 32'(bus.uaddr), 32'(vecs[i].exp_uaddr));
            checkOutput($sformatf("vec%0d_sp", i), 32'(bus.sp), 32'(vecs[i].exp_sp));
            checkOutput($sformatf("vec%0d_halted", i), 32'(bus.halted), 32'(vecs[i].exp_halted));
            checkOutput($sformatf("vec%0d_ovf", i), 32'(bus.err_ovf), 32'(vecs[i].exp_ovf));
            checkOutput($sformatf("vec%0d_unf", i), 32'(bus.err_unf), 32'(vecs[i].exp_unf));
        end

        // Asynchronous reset between edges after a CALL (uaddr=20, sp=1, all flags set).
        #3;
        resetn = 1'b0;
        #1;
        checkOutput("async_uaddr", 32'(bus.uaddr), 32'd0);
        checkOutput("async_sp", 32'(bus.sp), 32'd0);
        checkOutput("async_halted", 32'(bus.halted), 32'd0);
        checkOutput("async_ovf", 32'(bus.err_ovf), 32'd0);
        checkOutput("async_unf", 32'(bus.err_unf), 32'd0);
        applyStimulus(JMP, 2'd0, 1'b0, 5'd9, 5'd0, 5'd0, 4'd0, 1'b0);
        checkOutput("inreset_uaddr", 32'(bus.uaddr), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        applyStimulus(SEQ, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0);
        checkOutput("postreset_uaddr", 32'(bus.uaddr), 32'd1);
        applyStimulus(RET, 2'd0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0);
        checkOutput("postreset_ret_uaddr", 32'(bus.uaddr), 32'd1);
        checkOutput("postreset_ret_unf", 32'(bus.err_unf), 32'd1);
        checkOutput("postreset_ret_sp", 32'(bus.sp), 32'd0);

        // Random stimulus against the behavioural model.
        doReset();
        for (int i = 0; i < 400; i++) begin
            int ns, cs, cp, db, ib, sb, c, st;
            if (i % 100 == 99) doReset();
            ns = int'($urandom_range(0, 7));
            if (ns == 7 && $urandom_range(0, 3) != 0) ns = 5;
            cs = int'($urandom_range(0, 3));
            cp = int'($urandom_range(0, 1));
            db = int'($urandom_range(0, 31));
            ib = int'($urandom_range(0, 31));
            sb = int'($urandom_range(0, 31));
            c  = int'($urandom_range(0, 15));
            st = ($urandom_range(0, 4) == 0) ? 1 : 0;
            modelStep(ns, cs, cp, db, ib, sb, c, st);
            applyStimulus(3'(ns), 2'(cs), 1'(cp), 5'(db), 5'(ib), 5'(sb), 4'(c), 1'(st));
            checkModel($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
